// File: rtl/cb_cfg_pkg.sv
// Shared sizing helpers, default geometry and FSM encoding for the serially configured connection block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cb_cfg_pkg;

    // Default tile geometry
    localparam int DEF_WS         = 7;
    localparam int DEF_WD         = 6;
    localparam int DEF_WG         = 3;
    localparam int DEF_CLBIN      = 6;
    localparam int DEF_CLBIN0     = 2;
    localparam int DEF_CLBIN1     = 2;
    localparam int DEF_CLBOUT     = 2;
    localparam int DEF_CLBOUT0    = 2;
    localparam int DEF_CLBOUT1    = 2;
    localparam int DEF_CARRY      = 1;
    localparam int DEF_CLBOS      = 2;
    localparam int DEF_CLBOS_BIAS = 1;
    localparam int DEF_CLBOD      = 2;
    localparam int DEF_CLBOD_BIAS = 1;
    localparam int DEF_CLBX       = 1;

    // Output mux: select 0 is pass-through, 1..n_out pick a CLB output
    function automatic int sel_out_w(input int n_out);
        return $clog2(n_out + 1);
    endfunction

    // Input mux candidate count: both sides' singles and doubles, globals, cross-CLB outputs
    function automatic int in_cands(input int ws, input int wd, input int wg, input int n_x);
        return 2 * (ws + wd) + wg + n_x;
    endfunction

    function automatic int sel_in_w(input int ws, input int wd, input int wg, input int n_x);
        return $clog2(in_cands(ws, wd, wg, n_x));
    endfunction

    // Derived sizes and field bases for the default geometry (CFG_W = 44)
    localparam int SEL_PER_OUT = sel_out_w(DEF_CLBOUT0 + DEF_CLBOUT1);
    localparam int SEL_PER_IN0 = sel_in_w(DEF_WS, DEF_WD, DEF_WG, DEF_CLBX * DEF_CLBOUT1);
    localparam int SEL_PER_IN1 = sel_in_w(DEF_WS, DEF_WD, DEF_WG, DEF_CLBX * DEF_CLBOUT0);
    localparam int OS_BASE     = 0;
    localparam int OD_BASE     = OS_BASE + SEL_PER_OUT * 2 * DEF_CLBOS;
    localparam int IN0_BASE    = OD_BASE + SEL_PER_OUT * 2 * DEF_CLBOD;
    localparam int IN1_BASE    = IN0_BASE + SEL_PER_IN0 * DEF_CLBIN0;
    localparam int CFG_W       = IN1_BASE + SEL_PER_IN1 * DEF_CLBIN1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } cb_state_e;

endpackage

// File: rtl/cb_cfg_chain.sv
// Serial config chain: shadow shift register, load counter, FSM and active (live) copy.
// Latency: one clk per shifted bit; active updates on the commit edge, cfg_done the same edge.
// Backpressure: none; commits before a full load are refused and flagged on sticky cfg_err.
// Optional: CB_READBACK_EN lets an IDLE commit (no shift) reload shadow from active for readout.
module cb_cfg_chain
    import cb_cfg_pkg::*;
#(
    parameter int W = CFG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_din,
    input  logic         cfg_commit,
    output logic         cfg_dout,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic [W-1:0] active
);

    localparam int                CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

    cb_state_e        state;
    cb_state_e        state_n;
    logic [W-1:0]     shadow;
    logic [W-1:0]     shadow_sh;
    logic [W-1:0]     shadow_n;
    logic [W-1:0]     active_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_sh;
    logic [CNT_W-1:0] count_n;
    logic             done_n;
    logic             err_n;

    assign cfg_dout = shadow[0];

    // Shift step: happens on cfg_en regardless of commit, so a same-cycle commit sees the shifted data
    always_comb begin
        shadow_sh = shadow;
        count_sh  = count;
        if (cfg_en) begin
            shadow_sh = {cfg_din, shadow[W-1:1]};
            if (count != CNT_FULL) begin
                count_sh = count + 1'b1;
            end
        end
    end

    // FSM: shifting advances IDLE->SHIFT->FULL; commit is only honoured once a full frame is loaded
    always_comb begin
        shadow_n = shadow_sh;
        count_n  = count_sh;
        active_n = active;
        state_n  = state;
        done_n   = 1'b0;
        err_n    = cfg_err;
        if (cfg_en) begin
            state_n = (count_sh == CNT_FULL) ? FULL : SHIFT;
        end
        if (cfg_commit) begin
            if (state == FULL) begin
                active_n = shadow_sh;
                done_n   = 1'b1;
                state_n  = IDLE;
                count_n  = '0;
            end
`ifdef CB_READBACK_EN
            else if (state == IDLE && !cfg_en) begin
                shadow_n = active;
                count_n  = CNT_FULL;
                state_n  = FULL;
            end
`endif
            else begin
                err_n = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial load and the live configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= '0;
            active   <= '0;
            count    <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            shadow   <= shadow_n;
            active   <= active_n;
            count    <= count_n;
            cfg_done <= done_n;
            cfg_err  <= err_n;
        end
    end

endmodule

// File: rtl/connection_block_cfgchain.sv
// Unidirectional connection block whose mux selects come from a serial, double-buffered config chain.
// Latency: routing is combinational from the active config; a commit is visible right after its edge.
// Backpressure: none; the chain never stalls, early commits only raise cfg_err (CB_READBACK_EN adds readback).
module connection_block_cfgchain
    import cb_cfg_pkg::*;
#(
    parameter int WS         = DEF_WS,
    parameter int WD         = DEF_WD,
    parameter int WG         = DEF_WG,
    parameter int CLBIN      = DEF_CLBIN,
    parameter int CLBIN0     = DEF_CLBIN0,
    parameter int CLBIN1     = DEF_CLBIN1,
    parameter int CLBOUT     = DEF_CLBOUT,
    parameter int CLBOUT0    = DEF_CLBOUT0,
    parameter int CLBOUT1    = DEF_CLBOUT1,
    parameter int CARRY      = DEF_CARRY,
    parameter int CLBOS      = DEF_CLBOS,
    parameter int CLBOS_BIAS = DEF_CLBOS_BIAS,
    parameter int CLBOD      = DEF_CLBOD,
    parameter int CLBOD_BIAS = DEF_CLBOD_BIAS,
    parameter int CLBX       = DEF_CLBX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WS-1:0]     single0_in,
    input  logic [WS-1:0]     single1_in,
    output logic [WS-1:0]     single0_out,
    output logic [WS-1:0]     single1_out,
    input  logic [WD-1:0]     double0_in,
    input  logic [WD-1:0]     double1_in,
    output logic [WD-1:0]     double0_out,
    output logic [WD-1:0]     double1_out,
    // "global" is a reserved word, so the global lines use this name
    input  logic [WG-1:0]     global_line,
    input  logic [CLBOUT-1:0] clb0_output,
    input  logic [CLBOUT-1:0] clb1_output,
    input  logic [CARRY-1:0]  clb0_cout,
    input  logic [CARRY-1:0]  clb1_cout,
    output logic [CLBIN-1:0]  clb0_input,
    output logic [CLBIN-1:0]  clb1_input,
    output logic [CARRY-1:0]  clb0_cin,
    output logic [CARRY-1:0]  clb1_cin,
    input  logic              cfg_en,
    input  logic              cfg_din,
    output logic              cfg_dout,
    input  logic              cfg_commit,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int N_OUT  = CLBOUT0 + CLBOUT1;
    localparam int SO_W   = sel_out_w(N_OUT);
    localparam int N_BASE = 2 * (WS + WD) + WG;
    localparam int N_IN0  = in_cands(WS, WD, WG, CLBX * CLBOUT1);
    localparam int N_IN1  = in_cands(WS, WD, WG, CLBX * CLBOUT0);
    localparam int SI0_W  = $clog2(N_IN0);
    localparam int SI1_W  = $clog2(N_IN1);
    localparam int OD_B   = SO_W * 2 * CLBOS;
    localparam int IN0_B  = OD_B + SO_W * 2 * CLBOD;
    localparam int IN1_B  = IN0_B + SI0_W * CLBIN0;
    localparam int CW     = IN1_B + SI1_W * CLBIN1;

    logic [CW-1:0]     active;
    logic [N_OUT-1:0]  out_cand;
    logic [N_BASE-1:0] base_cand;
    logic [N_IN0-1:0]  in0_cand;
    logic [N_IN1-1:0]  in1_cand;

    cb_cfg_chain #(
        .W (CW)
    ) u_chain (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_din    (cfg_din),
        .cfg_commit (cfg_commit),
        .cfg_dout   (cfg_dout),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .active     (active)
    );

    // Carry chain simply crosses between the two CLBs
    assign clb0_cin = clb1_cout;
    assign clb1_cin = clb0_cout;

    // Output mux candidates; select k picks entry k-1, CLB0 outputs in the low entries
    assign out_cand  = {clb1_output[CLBOUT1-1:0], clb0_output[CLBOUT0-1:0]};
    // Input mux candidates shared by both CLBs, single1_out at the LSB
    assign base_cand = {global_line, double0_out, double1_out, single0_out, single1_out};

    // Track outputs: pass-through unless a targeted track's field selects a CLB output
    always_comb begin
        int t;
        int s;
        t           = 0;
        s           = 0;
        single1_out = single0_in;
        single0_out = single1_in;
        double1_out = double0_in;
        double0_out = double1_in;
        for (int i = 0; i < CLBOS; i++) begin
            t = (i + CLBOS_BIAS * CLBOS) % WS;
            s = int'(active[SO_W * (2 * i) +: SO_W]);
            if (s >= 1 && s <= N_OUT) single1_out[t] = out_cand[s - 1];
            s = int'(active[SO_W * (2 * i + 1) +: SO_W]);
            if (s >= 1 && s <= N_OUT) single0_out[t] = out_cand[s - 1];
        end
        // Only the lower half of the doubles is drivable; the upper half always passes through
        for (int i = 0; i < CLBOD; i++) begin
            t = (i + CLBOD_BIAS * CLBOD) % (WD / 2);
            s = int'(active[OD_B + SO_W * (2 * i) +: SO_W]);
            if (s >= 1 && s <= N_OUT) double1_out[t] = out_cand[s - 1];
            s = int'(active[OD_B + SO_W * (2 * i + 1) +: SO_W]);
            if (s >= 1 && s <= N_OUT) double0_out[t] = out_cand[s - 1];
        end
    end

    // CLB input muxes; out-of-range selects fall back to candidate 0, unused input bits stay 0
    always_comb begin
        int s;
        s          = 0;
        in0_cand   = '0;
        in1_cand   = '0;
        in0_cand[N_BASE-1:0] = base_cand;
        in1_cand[N_BASE-1:0] = base_cand;
        for (int k = 0; k < CLBX * CLBOUT1; k++) in0_cand[N_BASE + k] = clb1_output[k];
        for (int k = 0; k < CLBX * CLBOUT0; k++) in1_cand[N_BASE + k] = clb0_output[k];
        clb0_input = '0;
        clb1_input = '0;
        for (int j = 0; j < CLBIN0; j++) begin
            s = int'(active[IN0_B + SI0_W * j +: SI0_W]);
            clb0_input[j] = (s < N_IN0) ? in0_cand[s] : in0_cand[0];
        end
        for (int j = 0; j < CLBIN1; j++) begin
            s = int'(active[IN1_B + SI1_W * j +: SI1_W]);
            clb1_input[j] = (s < N_IN1) ? in1_cand[s] : in1_cand[0];
        end
    end

endmodule
